// File: rtl/spi_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_txn_arbiter
// Description : Round-robin arbiter sharing one SPI core between NREQ
//               requesters. Optional XFER timeout: define SPI_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_txn_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] req_data_i,
    output logic [NREQ-1:0]       gnt_o,
    output logic [NREQ-1:0]       done_o,
    output logic [WIDTH-1:0]      rx_data_o,
    output logic                  err_o,
    output logic                  busy_o,
    output logic                  spi_en_o,
    output logic [WIDTH-1:0]      spi_tx_o,
    input  logic                  spi_done_i,
    input  logic [WIDTH-1:0]      spi_rx_i
);

    localparam int c_idx_w = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] c_one = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_XFER  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [NREQ-1:0]      r_gnt;
    logic [WIDTH-1:0]     r_tx;
    logic [WIDTH-1:0]     r_rx;
    logic [c_idx_w-1:0]   r_last;
    logic [c_idx_w-1:0]   w_lo;
    logic [c_idx_w-1:0]   w_hi;
    logic                 w_hi_vld;
    logic [c_idx_w-1:0]   w_winner;
    logic [WIDTH-1:0]     w_tx_sel;
    logic                 w_expire;
    logic                 w_start;

    // Round-robin: lowest requester above r_last, else lowest overall (wrap).
    always_comb begin
        w_lo     = '0;
        w_hi     = '0;
        w_hi_vld = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                w_lo = c_idx_w'(i);
                if (c_idx_w'(i) > r_last) begin
                    w_hi     = c_idx_w'(i);
                    w_hi_vld = 1'b1;
                end
            end
        end
        w_winner = w_hi_vld ? w_hi : w_lo;
    end

    always_comb begin
        w_tx_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner == c_idx_w'(i)) begin
                w_tx_sel = req_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_start = (r_state == S_IDLE) && (|req_i);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (|req_i) w_next = S_GRANT;
            S_GRANT: w_next = S_XFER;
            S_XFER:  if (spi_done_i || w_expire) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_gnt  <= '0;
            r_tx   <= '0;
            r_rx   <= '0;
            r_last <= c_idx_w'(NREQ - 1);
        end else begin
            if (w_start) begin
                r_gnt  <= c_one << w_winner;
                r_tx   <= w_tx_sel;
                r_last <= w_winner;
            end
            if (r_state == S_XFER) begin
                if (spi_done_i) begin
                    r_rx <= spi_rx_i;
                end else if (w_expire) begin
                    r_rx <= '0;
                end
            end
            if (r_state == S_DONE) begin
                r_gnt <= '0;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int c_cnt_raw = $clog2(TIMEOUT + 1);
    localparam int c_cnt_w   = (c_cnt_raw < 8) ? 8 : ((c_cnt_raw > 16) ? 16 : c_cnt_raw);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_err;

    // Counter is zero on XFER entry; expiry after TIMEOUT XFER cycles.
    assign w_expire = (r_state == S_XFER) && (r_cnt == c_cnt_w'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_XFER) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (r_state == S_XFER) begin
                r_err <= w_expire && !spi_done_i;
            end else if (r_state == S_DONE) begin
                r_err <= 1'b0;
            end
        end
    end

    assign err_o = r_err && (r_state == S_DONE);
`else
    assign w_expire = 1'b0;
    assign err_o    = 1'b0;
`endif

    assign gnt_o     = r_gnt;
    assign done_o    = r_gnt & {NREQ{r_state == S_DONE}};
    assign rx_data_o = r_rx;
    assign busy_o    = (r_state != S_IDLE);
    assign spi_en_o  = (r_state == S_XFER);
    assign spi_tx_o  = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_spi_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_txn_arbiter
// Description : Randomized self-checking bench for spi_txn_arbiter against a
//               transaction-level round-robin model. Honours SPI_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_txn_arbiter;

    localparam int W = 8;
    localparam int N = 4;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TMO    = 10;
    localparam int LONG_D = 9;
    localparam int MAX_D  = 9;
`else
    localparam int TMO    = 255;
    localparam int LONG_D = 20;
    localparam int MAX_D  = 20;
`endif

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic [N-1:0]   req_i;
    logic [N*W-1:0] req_data_i;
    logic [N-1:0]   gnt_o;
    logic [N-1:0]   done_o;
    logic [W-1:0]   rx_data_o;
    logic           err_o;
    logic           busy_o;
    logic           spi_en_o;
    logic [W-1:0]   spi_tx_o;
    logic           spi_done_i;
    logic [W-1:0]   spi_rx_i;

    spi_txn_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(TMO)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .req_i      (req_i),
        .req_data_i (req_data_i),
        .gnt_o      (gnt_o),
        .done_o     (done_o),
        .rx_data_o  (rx_data_o),
        .err_o      (err_o),
        .busy_o     (busy_o),
        .spi_en_o   (spi_en_o),
        .spi_tx_o   (spi_tx_o),
        .spi_done_i (spi_done_i),
        .spi_rx_i   (spi_rx_i)
    );

    always #5 clk_i = ~clk_i;

    int           n_checks = 0;
    int           n_pass   = 0;
    int           last_m   = N - 1;
    logic [W-1:0] exp_rx   = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: first requesting index in order last+1, last+2, ... mod N.
    function automatic int pred(input logic [N-1:0] pat);
        for (int k = 1; k <= N; k++) begin
            if (pat[(last_m + k) % N]) return (last_m + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic txn(input logic [N-1:0] pat, input logic [N*W-1:0] data, input int delay,
                       input bit perturb, input bit hold, input logic [W-1:0] rx);
        int           w;
        logic [W-1:0] tx;
        w  = pred(pat);
        tx = data[w*W +: W];
        req_i      = pat;
        req_data_i = data;
        tick();
        check_eq("grant", 32'(gnt_o), 32'(onehot(w)));
        check_eq("tx_latch", 32'(spi_tx_o), 32'(tx));
        check_eq("grant_busy", 32'(busy_o), 32'd1);
        check_eq("grant_en_low", 32'(spi_en_o), 32'd0);
        if (perturb) begin
            req_i      = '0;
            req_data_i = ~data;
        end
        tick();
        check_eq("xfer_en", 32'(spi_en_o), 32'd1);
        repeat (delay) tick();
        check_eq("xfer_en_hold", 32'(spi_en_o), 32'd1);
        check_eq("xfer_tx_hold", 32'(spi_tx_o), 32'(tx));
        spi_rx_i   = rx;
        spi_done_i = 1'b1;
        tick();
        spi_done_i = 1'b0;
        exp_rx     = rx;
        last_m     = w;
        check_eq("done", 32'(done_o), 32'(onehot(w)));
        check_eq("rx_data", 32'(rx_data_o), 32'(exp_rx));
        check_eq("err_clear", 32'(err_o), 32'd0);
        check_eq("done_en_low", 32'(spi_en_o), 32'd0);
        tick();
        check_eq("idle_busy", 32'(busy_o), 32'd0);
        check_eq("idle_gnt", 32'(gnt_o), 32'd0);
        check_eq("idle_done", 32'(done_o), 32'd0);
        check_eq("idle_en_low", 32'(spi_en_o), 32'd0);
        check_eq("idle_rx_held", 32'(rx_data_o), 32'(exp_rx));
        if (!hold) req_i = '0;
    endtask

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom);
        return d;
    endfunction

    initial begin
        int           w;
        int           cyc;
        logic [N-1:0] pat;

        reset_i    = 1'b0;
        req_i      = '0;
        req_data_i = '0;
        spi_done_i = 1'b0;
        spi_rx_i   = '0;
        repeat (3) tick();
        check_eq("rst_gnt", 32'(gnt_o), 32'd0);
        check_eq("rst_done", 32'(done_o), 32'd0);
        check_eq("rst_rx", 32'(rx_data_o), 32'd0);
        check_eq("rst_err", 32'(err_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_en", 32'(spi_en_o), 32'd0);
        check_eq("rst_tx", 32'(spi_tx_o), 32'd0);
        reset_i = 1'b1;
        tick();

        txn(4'b0001, 32'h0000_00A5, LONG_D, 1'b0, 1'b0, 8'h3C);

        // Completion strobe while idle must be ignored.
        spi_rx_i   = 8'hFF;
        spi_done_i = 1'b1;
        tick();
        spi_done_i = 1'b0;
        check_eq("spur_busy", 32'(busy_o), 32'd0);
        check_eq("spur_done", 32'(done_o), 32'd0);
        check_eq("spur_rx", 32'(rx_data_o), 32'(exp_rx));
        tick();
        check_eq("spur_busy2", 32'(busy_o), 32'd0);

        for (int i = 0; i < 5; i++)
            txn(4'b1111, rand_data(), $urandom_range(0, MAX_D), 1'b0, i != 4, W'($urandom));

        txn(4'b0100, rand_data(), $urandom_range(0, MAX_D), 1'b1, 1'b0, W'($urandom));

        for (int i = 0; i < 40; i++) begin
            pat = N'($urandom_range(1, (1 << N) - 1));
            txn(pat, rand_data(), $urandom_range(0, MAX_D), 1'($urandom_range(0, 1)),
                (i != 39) && 1'($urandom_range(0, 1)), W'($urandom));
        end

        // Transfer with no completion strobe.
        pat = 4'b0010;
        w   = pred(pat);
        req_i      = pat;
        req_data_i = rand_data();
        tick();
        req_i = '0;
        tick();
        check_eq("stall_en", 32'(spi_en_o), 32'd1);
`ifdef SPI_ARB_TIMEOUT_EN
        cyc = 1;
        while (done_o == '0 && cyc < 3 * TMO) begin
            tick();
            cyc++;
        end
        check_eq("tmo_cycle", 32'(cyc), 32'(TMO + 1));
        check_eq("tmo_done", 32'(done_o), 32'(onehot(w)));
        check_eq("tmo_err", 32'(err_o), 32'd1);
        check_eq("tmo_rx", 32'(rx_data_o), 32'd0);
        exp_rx = '0;
`else
        repeat (1000) tick();
        check_eq("hang_busy", 32'(busy_o), 32'd1);
        check_eq("hang_en", 32'(spi_en_o), 32'd1);
        spi_rx_i   = 8'h5A;
        spi_done_i = 1'b1;
        tick();
        spi_done_i = 1'b0;
        exp_rx     = 8'h5A;
        check_eq("hang_done", 32'(done_o), 32'(onehot(w)));
        check_eq("hang_rx", 32'(rx_data_o), 32'(exp_rx));
`endif
        last_m = w;
        tick();
        check_eq("post_stall_busy", 32'(busy_o), 32'd0);

        // Asynchronous reset in the middle of a transfer.
        req_i      = 4'b0100;
        req_data_i = rand_data();
        tick();
        tick();
        check_eq("pre_rst_en", 32'(spi_en_o), 32'd1);
        #2;
        reset_i = 1'b0;
        #1;
        check_eq("arst_en", 32'(spi_en_o), 32'd0);
        check_eq("arst_gnt", 32'(gnt_o), 32'd0);
        check_eq("arst_busy", 32'(busy_o), 32'd0);
        check_eq("arst_done", 32'(done_o), 32'd0);
        req_i = '0;
        tick();
        reset_i = 1'b1;
        last_m  = N - 1;
        exp_rx  = '0;
        tick();
        check_eq("post_rst_busy", 32'(busy_o), 32'd0);
        txn(4'b1111, rand_data(), 3, 1'b0, 1'b0, W'($urandom));
        check_eq("post_rst_winner", 32'(last_m), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
